vh_parity_decoder_stream: RTL
=============================

Name: vh_parity_decoder_stream

Overview:
- Parametrised two-dimensional (row/column) parity decoder for a ROWS x COLS data block, with a valid/ready streaming interface.
- Corrects any single data-bit error and classifies parity-bit errors and uncorrectable patterns.
- Keeps saturating correction and uncorrectable event counters.
- Sits on the decode side of the vertical/horizontal codec, after the channel and before the consumer of the data.

Parameters:
- ROWS, 4, number of data rows; each row has one horizontal parity bit.
- COLS, 4, number of data columns; each column has one vertical parity bit.
- CNT_W, 16, width of each event counter.
- Derived D = ROWS*COLS (data width) and CW = D+ROWS+COLS (codeword width); neither is user-settable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_data  in  CW  codeword
  - bits [D-1:0]: data, row-major; bit r*COLS+c is row r, column c.
  - bits [D+ROWS-1:D]: row parity.
  - bits [CW-1:D+ROWS]: column parity.
- in_valid  in  1  codeword present
- in_ready  out  1  decoder accepts in_data this cycle
- out_data  out  D  corrected data
- out_status  out  2  status code
  - 00: clean
  - 01: data bit corrected
  - 10: single parity-bit error, data untouched
  - 11: uncorrectable
- out_valid  out  1  out_data/out_status valid
- out_ready  in  1  downstream accepts
- cnt_clr  in  1  synchronous clear of both counters
- corr_count  out  CNT_W  saturating count of status 01 or 10 outputs
- uncorr_count  out  CNT_W  saturating count of status 11 outputs

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_status=00, corr_count=0, uncorr_count=0.
  - Both pipeline stage valids cleared; any in-flight words are discarded.
  - in_ready=1 from the first cycle after reset.
- Pipeline structure:
  - Two register stages.
  - S1 captures in_data on the input handshake.
  - S2 holds the decoded result, which drives out_*.
  - Advance enable en = !out_valid | out_ready.
  - in_ready = en (combinational; in_ready does not depend on in_valid).
- Stage updates when en=1:
  - S1 valid <= in_valid.
  - S1 data <= in_data, loaded only if in_valid=1.
  - S2 valid <= S1 valid.
  - S2 data/status <= decode(S1 data), loaded only if S1 valid=1.
- When en=0, both stages hold. out_data/out_status are stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input handshake to out_valid with no backpressure; full throughput of 1 word/cycle.
- Decode (combinational between S1 and S2):
  - hs[r] = XOR of row r data bits ^ row parity bit r.
  - vs[c] = XOR of column c data bits ^ column parity bit c.
  - nr = popcount(hs), nc = popcount(vs).
- Status classification:
  - nr=0, nc=0: status 00; data passed unchanged.
  - nr=1, nc=1: status 01; out_data[r*COLS+c] = data ^ (hs[r] & vs[c]) for all r, c, which flips exactly one bit.
  - (nr=1, nc=0) or (nr=0, nc=1): status 10; data passed unchanged.
  - Any other combination: status 11; data passed uncorrected, never partially corrected.
- Counters:
  - Update on an output handshake (out_valid & out_ready).
  - Status 01 or 10 increments corr_count; status 11 increments uncorr_count.
  - Saturate at 2^CNT_W-1, with no wrap.
  - cnt_clr=1 zeroes both counters and wins over a coincident increment in the same cycle.
  - rst zeroes both counters.
- Parameter legality: ROWS>=2 and COLS>=2; any other value is illegal and elaboration fails.

Test Plan:
- Clean word, ROWS=COLS=4: in_data=24'h00A5C3 with out_ready=1 -> 2 cycles later out_data=16'hA5C3, out_status=00, both counters stay 0.
- Single data error: in_data=24'h00A5E3 (bit 5 flipped) -> out_data=16'hA5C3, status=01, corr_count=1.
- Parity-bit error: in_data=24'h02A5C3 (row parity bit 1 flipped) -> out_data=16'hA5C3, status=10, corr_count increments.
- Double error: in_data=24'h00A5E2 (bits 0 and 5 flipped; nr=2, nc=2) -> out_data=16'hA5E2, status=11, uncorr_count=1.
- Backpressure: stream 4 back-to-back words while holding out_ready=0 from cycle 3 for 5 cycles.
  - in_ready drops once both stages are full.
  - out_data holds steady while out_ready=0.
  - All 4 words emerge in order with no loss or duplication.
  - Counters increment once per word.
- Saturation, clear and reset, with CNT_W=2, ROWS=8, COLS=2:
  - 5 single-error words -> corr_count sticks at 3.
  - cnt_clr asserted together with a correcting handshake -> count 0.
  - rst asserted mid-stream -> out_valid=0 on the next cycle, and no pre-reset word appears afterwards.

Source files
------------

// File: rtl/vh_parity_decoder_stream.sv
// Row/column parity decoder for a ROWS x COLS data block with a two-stage
// valid/ready pipeline and saturating correction/uncorrectable event counters.
module vh_parity_decoder_stream #(
   parameter int unsigned ROWS  = 4,
   parameter int unsigned COLS  = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [ROWS*COLS+ROWS+COLS-1:0]    in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [ROWS*COLS-1:0]              out_data,
   output logic [1:0]                        out_status,
   output logic                              out_valid,
   input  logic                              out_ready,
   input  logic                              cnt_clr,
   output logic [CNT_W-1:0]                  corr_count,
   output logic [CNT_W-1:0]                  uncorr_count
);

   localparam int unsigned D  = ROWS * COLS;
   localparam int unsigned CW = D + ROWS + COLS;

   if (ROWS < 2 || COLS < 2) begin : g_param_check
      $error("vh_parity_decoder_stream: ROWS and COLS must both be >= 2");
   end

   typedef enum logic [1:0] {
      ST_CLEAN   = 2'b00,
      ST_CORR    = 2'b01,
      ST_PAR_ERR = 2'b10,
      ST_UNCORR  = 2'b11
   } status_e;

   logic            en;
   logic            s1_valid;
   logic [CW-1:0]   s1_data;
   logic [ROWS-1:0] hs;
   logic [COLS-1:0] vs;
   logic [D-1:0]    fix_mask;
   logic [D-1:0]    dec_data;
   status_e         dec_status;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Syndromes: each row/column XOR includes its own parity bit, so zero means consistent.
   always_comb begin
      hs       = '0;
      vs       = '0;
      fix_mask = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         hs[r] = s1_data[D + r];
         for (int unsigned c = 0; c < COLS; c++) begin
            hs[r] = hs[r] ^ s1_data[r*COLS + c];
         end
      end
      for (int unsigned c = 0; c < COLS; c++) begin
         vs[c] = s1_data[D + ROWS + c];
         for (int unsigned r = 0; r < ROWS; r++) begin
            vs[c] = vs[c] ^ s1_data[r*COLS + c];
         end
      end
      for (int unsigned r = 0; r < ROWS; r++) begin
         for (int unsigned c = 0; c < COLS; c++) begin
            fix_mask[r*COLS + c] = hs[r] & vs[c];
         end
      end
   end

   // The mask is applied only for the one-row/one-column case; any wider
   // syndrome leaves the data untouched rather than partially corrected.
   always_comb begin
      dec_data   = s1_data[D-1:0];
      dec_status = ST_UNCORR;
      if (hs == '0 && vs == '0) begin
         dec_status = ST_CLEAN;
      end else if ($onehot(hs) && $onehot(vs)) begin
         dec_status = ST_CORR;
         dec_data   = s1_data[D-1:0] ^ fix_mask;
      end else if (($onehot(hs) && vs == '0) || (hs == '0 && $onehot(vs))) begin
         dec_status = ST_PAR_ERR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_data    <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_status <= ST_CLEAN;
      end else if (en) begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         if (in_valid) begin
            s1_data <= in_data;
         end
         if (s1_valid) begin
            out_data   <= dec_data;
            out_status <= dec_status;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         corr_count   <= '0;
         uncorr_count <= '0;
      end else if (out_valid && out_ready) begin
         case (out_status)
            ST_CORR, ST_PAR_ERR: begin
               if (corr_count != '1) begin
                  corr_count <= corr_count + 1'b1;
               end
            end
            ST_UNCORR: begin
               if (uncorr_count != '1) begin
                  uncorr_count <= uncorr_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
